// File: rtl/tick_sample_fifo.sv
// tick_sample_fifo: Avalon-MM sample FIFO popped on timer tick edges; `define TICK_SAMPLE_FIFO_TIMESTAMP_EN adds a tick counter at address 5
module tick_sample_fifo #(
  parameter int DATA_W       = 16,
  parameter int DEPTH_LOG2   = 6,
  parameter int RESET_THRESH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  input  logic              tick,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              irq
);
  localparam int LW = DEPTH_LOG2 + 1;
  logic [DATA_W-1:0]     mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0]         level, thresh;
  logic                  enable, irq_en, hold_last, uf_sticky, of_sticky, tick_d;
  logic [15:0]           uf_count, rd_mux;
  logic [7:0]            wr;
  logic                  tick_evt, pop, uf, push, flush, full, empty, low;
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
  logic [15:0]           tick_count;
`endif
  assign wr       = {8{chipselect & ~write_n}} & (8'd1 << address);
  assign tick_evt = tick & ~tick_d & enable;
  assign empty    = level == '0;
  assign full     = level == LW'(1 << DEPTH_LOG2);
  assign low      = level <= thresh;
  assign pop      = tick_evt & ~empty;
  assign uf       = tick_evt & empty;
  assign push     = wr[0] & (~full | pop);
  assign flush    = wr[1] & writedata[2];
  assign irq      = irq_en & enable & low;
  // register read mux; unmapped addresses read zero
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = 16'(level);
      3'd1: rd_mux = {12'd0, hold_last, 1'b0, irq_en, enable};
      3'd2: rd_mux = 16'(thresh);
      3'd3: rd_mux = {11'd0, low, of_sticky, uf_sticky, full, empty};
      3'd4: rd_mux = uf_count;
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
      3'd5: rd_mux = tick_count;
`endif
      default: rd_mux = '0;
    endcase
  end
  // storage array carries no reset; contents are don't-care after reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= DATA_W'(writedata);
  // FIFO bookkeeping; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= flush ? '0 : pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      wr_ptr <= flush ? '0 : push ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      level  <= flush ? '0 : level + LW'(push) - LW'(pop);
    end
  // output stage: pop the head, or hold/zero on underflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tick_d       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      readdata     <= '0;
    end else begin
      tick_d       <= tick;
      sample_valid <= tick_evt;
      readdata     <= rd_mux;
      if (tick_evt) sample_out <= pop ? mem[rd_ptr] : hold_last ? sample_out : '0;
    end
  // control, threshold, sticky status and underflow counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      hold_last <= 1'b0;
      thresh    <= LW'(RESET_THRESH);
      uf_sticky <= 1'b0;
      of_sticky <= 1'b0;
      uf_count  <= '0;
    end else begin
      if (wr[1]) {hold_last, irq_en, enable} <= {writedata[3], writedata[1:0]};
      if (wr[2]) thresh <= writedata[LW-1:0];
      uf_sticky <= (uf_sticky & ~wr[3]) | uf;
      of_sticky <= (of_sticky & ~wr[3]) | (wr[0] & ~push);
      uf_count  <= wr[4] ? '0 : (uf && uf_count != 16'hFFFF) ? uf_count + 16'd1 : uf_count;
    end
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
  // free-running count of accepted tick events
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tick_count <= '0;
    else tick_count <= wr[5] ? '0 : tick_evt ? tick_count + 16'd1 : tick_count;
`endif
endmodule

// File: tb/tb_tick_sample_fifo.sv
// tb_tick_sample_fifo: directed plus random checks of tick_sample_fifo against a queue-based reference model
module tb_tick_sample_fifo;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1, tick = 0;
  logic [2:0]  address = 0;
  logic [15:0] writedata = 0, readdata, sample_out;
  logic        sample_valid, irq;
  int n_chk = 0, n_fail = 0;
  int q[$];
  bit en, ie, hl, ufs, ofs, td, te_last;
  int th, ufc, tc, so;

  tick_sample_fifo dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .tick(tick),
    .sample_out(sample_out), .sample_valid(sample_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    {en, ie, hl, ufs, ofs, td} = '0;
    th = 16; ufc = 0; tc = 0; so = 0;
  endtask

  task automatic step();
    int lvl, e_rd;
    bit w, te, popped;
    lvl = q.size();
    w = chipselect && !write_n;
    case (address)
      0: e_rd = lvl;
      1: e_rd = int'(hl) * 8 + int'(ie) * 2 + int'(en);
      2: e_rd = th;
      3: e_rd = int'(lvl <= th) * 16 + int'(ofs) * 8 + int'(ufs) * 4 + int'(lvl == 64) * 2 + int'(lvl == 0);
      4: e_rd = ufc;
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
      5: e_rd = tc;
`endif
      default: e_rd = 0;
    endcase
    te = tick && !td && en;
    td = tick;
    popped = 0;
    if (w && address == 3) begin ufs = 0; ofs = 0; end
    if (te) begin
      if (lvl > 0) begin so = q.pop_front(); popped = 1; end
      else begin
        if (!hl) so = 0;
        ufs = 1;
        if (ufc < 65535) ufc++;
      end
    end
    if (w && address == 4) ufc = 0;
    if (w && address == 0) begin
      if (lvl < 64 || popped) q.push_back(int'(writedata)); else ofs = 1;
    end
    if (w && address == 1) begin
      en = writedata[0]; ie = writedata[1]; hl = writedata[3];
      if (writedata[2]) q.delete();
    end
    if (w && address == 2) th = int'(writedata[6:0]);
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
    if (w && address == 5) tc = 0; else if (te) tc = (tc + 1) % 65536;
`endif
    @(posedge clk); #1;
    chk("sample_out", sample_out, so);
    chk("sample_valid", sample_valid, te);
    chk("readdata", readdata, e_rd);
    chk("irq", irq, ie && en && (q.size() <= th));
  endtask

  task automatic wr_reg(input int a, input int d);
    address = 3'(a); chipselect = 1; write_n = 0; writedata = 16'(d);
    step();
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd_reg(input int a);
    address = 3'(a); chipselect = 1;
    step();
    chipselect = 0;
  endtask

  task automatic tick_pulse();
    tick = 1; step(); step();
    tick = 0; step();
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", irq, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    rd_reg(2); chk("thresh_reset", readdata, 16);
    rd_reg(3); chk("status_reset", readdata, 16'h0011);
    chk("irq_reset", irq, 0);
    wr_reg(1, 3);
    wr_reg(0, 'h1111);
    wr_reg(0, 'h2222);
    tick_pulse(); chk("pop_first", sample_out, 'h1111);
    step();
    tick_pulse(); chk("pop_second", sample_out, 'h2222);
    rd_reg(0); chk("level_drained", readdata, 0);
    chk("irq_low", irq, 1);
    for (int i = 0; i < 65; i++) wr_reg(0, 'h100 + i);
    rd_reg(0); chk("level_full", readdata, 64);
    rd_reg(3); chk("status_full_ovf", readdata, 16'h000A);
    tick_pulse(); chk("ovf_first_word", sample_out, 'h100);
    wr_reg(1, 7);
    wr_reg(0, 'hABCD);
    tick_pulse(); chk("abcd_popped", sample_out, 'hABCD);
    wr_reg(1, 'hB);
    wr_reg(3, 0);
    wr_reg(4, 0);
    repeat (3) tick_pulse();
    chk("hold_last", sample_out, 'hABCD);
    rd_reg(4); chk("ufcount3", readdata, 3);
    rd_reg(3); chk("status_uf", readdata, 16'h0015);
    wr_reg(3, 0);
    rd_reg(3); chk("status_cleared", readdata, 16'h0011);
    for (int i = 0; i < 10; i++) wr_reg(0, 'h500 + i);
    tick = 1;
    wr_reg(0, 'h5AA);
    chk("coincide_valid", sample_valid, 1);
    step(); tick = 0; step();
    rd_reg(0); chk("coincide_level", readdata, 10);
    tick = 1;
    wr_reg(1, 'h7);
    step(); tick = 0; step();
    rd_reg(0); chk("flush_level", readdata, 0);
    wr_reg(1, 3);
    wr_reg(2, 4);
    for (int i = 0; i < 5; i++) wr_reg(0, 'h600 + i);
    wr_reg(5, 0);
    chk("irq_above", irq, 0);
    tick_pulse(); chk("irq_at_thresh", irq, 1);
    rd_reg(0); chk("level4", readdata, 4);
`ifdef TICK_SAMPLE_FIFO_TIMESTAMP_EN
    rd_reg(5); chk("tick_count1", readdata, 1);
`else
    rd_reg(5); chk("addr5_zero", readdata, 0);
`endif
    do_reset();
    rd_reg(0); chk("level_after_reset", readdata, 0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      if (r < 22) wr_reg(0, $urandom_range(0, 65535));
      else if (r < 25) wr_reg(1, {$urandom_range(0, 1), int'($urandom_range(0, 19) == 0), $urandom_range(0, 1), int'($urandom_range(0, 7) != 0)} );
      else if (r < 27) wr_reg(2, $urandom_range(0, 127));
      else if (r < 29) wr_reg(3, $urandom_range(0, 65535));
      else if (r < 30) wr_reg(4, 0);
      else if (r < 31) wr_reg(5, 0);
      else rd_reg($urandom_range(0, 7));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
